prio_chain_arb_mux: RTL and testbench



---
 rtl/prio_chain_arb_pkg.sv | 15 +
 rtl/prio_chain_arb_mux_prio_pick.sv | 34 +++
 rtl/prio_chain_arb_mux.sv | 92 +++++++++
 tb/tb_prio_chain_arb_mux.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/prio_chain_arb_pkg.sv
// Shared types for the arbitrating selector: arbitration mode and
// output-stage occupancy.
package prio_chain_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage : prio_chain_arb_pkg

// File: rtl/prio_chain_arb_mux_prio_pick.sv
// Combinational circular priority picker: the first requester found when
// scanning upward from 'start' (wrapping modulo NUM_CH) wins.
module prio_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  int               idx;
  logic [SEL_W-1:0] idx_sel;

  // Loop search from start; the first hit locks the grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_sel = SEL_W'(idx);
      if (!gnt_valid && req[idx_sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_sel;
      end
    end
  end

endmodule : prio_pick

// File: rtl/prio_chain_arb_mux.sv
// N-channel arbitrating selector with a single registered output stage.
// Grants one valid channel per cycle (fixed priority or round-robin) whenever
// the output register is empty or being drained in the same cycle.
module prio_chain_arb_mux
  import prio_chain_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode_i,
  input  logic [NUM_CH-1:0]              in_valid_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data_i,
  output logic [NUM_CH-1:0]              in_ready_o,
  output logic                           out_valid_o,
  output logic [DATA_W-1:0]              out_data_o,
  output logic [SEL_W-1:0]               out_sel_o,
  input  logic                           out_ready_i
);

  arb_mode_e        mode;
  out_state_e       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr, rr_next;
  logic [SEL_W-1:0] pick_start;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             grant;

  assign mode        = arb_mode_e'(mode_i);
  assign out_valid_o = (state_q == OUT_FULL);
  assign load_en     = !out_valid_o || out_ready_i;
  // Holding reset suppresses grants so no producer sees a handshake.
  assign grant       = rst_n && load_en && gnt_valid;
  assign pick_start  = (mode == ARB_RR) ? rr_ptr : '0;

  prio_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req       (in_valid_i),
    .start     (pick_start),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // One-hot ready for the granted channel; zero when stalled or idle.
  always_comb begin
    in_ready_o = '0;
    if (grant) in_ready_o[gnt_idx] = 1'b1;
  end

  // Round-robin pointer advance: one past the winner, wrapping at NUM_CH-1.
  always_comb begin
    rr_next = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
  end

  // Output occupancy: fill on grant, drain when popped with nothing to refill.
  always_comb begin
    state_d = state_q;
    if (grant)        state_d = OUT_FULL;
    else if (load_en) state_d = OUT_EMPTY;
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  // Output word and source index, captured only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, since reset must visibly clear the held word.
    if (!rst_n) begin
      out_data_o <= '0;
      out_sel_o  <= '0;
    end else if (grant) begin
      out_data_o <= in_data_i[gnt_idx];
      out_sel_o  <= gnt_idx;
    end
  end

  // Round-robin pointer: moves only on a real grant made in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rr_ptr <= '0;
    else if (grant && mode == ARB_RR) rr_ptr <= rr_next;
  end

endmodule : prio_chain_arb_mux

// File: tb/tb_prio_chain_arb_mux.sv
// Directed bench for prio_chain_arb_mux (4 channels, 8-bit data).
module tb_prio_chain_arb_mux;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [3:0]      in_valid;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_sel;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  prio_chain_arb_mux #(
    .NUM_CH (4),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data[0] = 8'h10;
    in_data[1] = 8'h11;
    in_data[2] = 8'h12;
    in_data[3] = 8'h13;

    // Reset state, with inputs valid: no ready may leak out.
    #1;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    tick();

    // Fixed priority, all channels valid: channel 0 always wins.
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("fixed.in_ready0", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("fixed.stream", 1'b1, 8'h10, 2'd0);
      check("fixed.in_ready", 32'(in_ready), 32'b0001);
    end

    // Async reset while FULL clears the word immediately.
    rst_n = 1'b0;
    #1;
    check_out("rst1", 1'b0, 8'h00, 2'd0);

    // Round-robin from reset: 0,1,2,3,0,1.
    mode  = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out("rr.seq", 1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4));
    end

    // Reset mid-stream (rr_ptr was 2): sequence restarts at channel 0.
    rst_n = 1'b0;
    #1;
    check_out("rst2", 1'b0, 8'h00, 2'd0);
    check("rst2.in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("rr.restart", 1'b1, 8'(8'h10 + i), 2'(i));
    end

    // rr_ptr wrapped to 0; only channel 3 valid -> grant 3, ptr -> 0.
    in_valid = 4'b1000;
    #1;
    check("rr.only3.ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("rr.only3", 1'b1, 8'h13, 2'd3);
    in_valid = 4'b1010;
    #1;
    check("rr.c13a.ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("rr.c13a", 1'b1, 8'h11, 2'd1);
    #1;
    check("rr.c13b.ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("rr.c13b", 1'b1, 8'h13, 2'd3);

    // Backpressure: load 0xA5 from channel 0 (ptr 0 -> 1), then stall.
    in_valid   = 4'b0001;
    in_data[0] = 8'hA5;
    tick();
    check_out("bp.load", 1'b1, 8'hA5, 2'd0);
    in_data[0] = 8'h5A;
    in_valid   = 4'hF;
    out_ready  = 1'b0;
    #1;
    check("bp.ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp.hold", 1'b1, 8'hA5, 2'd0);
      check("bp.in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("bp.next", 1'b1, 8'h11, 2'd1);

    // Mode switch: rr_ptr is 2. Fixed with {0,2} valid -> 0.
    mode     = 1'b0;
    in_valid = 4'b0101;
    #1;
    check("sw.fixed.ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("sw.fixed", 1'b1, 8'h5A, 2'd0);
    // Back to RR: pointer kept at 2 -> grant 2.
    mode = 1'b1;
    #1;
    check("sw.rr.ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("sw.rr", 1'b1, 8'h12, 2'd2);

    // Drain with no valid inputs, then stay empty.
    in_valid = 4'h0;
    tick();
    check("drain.valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    tick();
    check("idle.valid", 32'(out_valid), 32'h0);
    check("idle.in_ready", 32'(in_ready), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_prio_chain_arb_mux
